// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, then a one-cycle response.
// Optional misaligned-access checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;

    logic            wr_q;
    logic [IW-1:0]   idx_q;
    logic [31:0]     wdata_q;

    logic            cur_wr;
    logic [IW-1:0]   cur_idx;
    logic [31:0]     cur_wdata;
    logic            cur_misal;

    logic            accept;
    logic            commit;
    logic            mem_we;

    logic [31:0]     mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    logic            misal_q;
    logic            err_q, err_d;
    logic            unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:IW+2];
`else
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IW+2], req_addr[1:0]};
`endif

    assign accept = (state_q == S_IDLE) && req_valid;

    // With zero wait states the commit edge is the accept edge, so the live request is used.
    always_comb begin
        cur_wr    = wr_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        cur_misal = misal_q;
`else
        cur_misal = 1'b0;
`endif
        if (state_q == S_IDLE) begin
            cur_wr    = req_write;
            cur_idx   = req_addr[IW+1:2];
            cur_wdata = req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
            cur_misal = (req_addr[1:0] != 2'b00);
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
        err_d   = err_q;
`endif
        if (commit) begin
            rdata_d = cur_wr ? 32'd0 : mem[cur_idx];
`ifdef DMEM_ALIGN_CHECK_EN
            if (cur_misal) begin
                rdata_d = 32'd0;
            end
            err_d = cur_misal;
`endif
        end
    end

    // Gating with the reset level keeps an asserted reset from racing a commit-edge write.
    assign mem_we = commit && cur_wr && !cur_misal && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
`ifdef DMEM_ALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            idx_q   <= req_addr[IW+1:2];
            wdata_q <= req_wdata;
`ifdef DMEM_ALIGN_CHECK_EN
            misal_q <= (req_addr[1:0] != 2'b00);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
`ifdef DMEM_ALIGN_CHECK_EN
    assign resp_err   = err_q & resp_valid;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a slow instance (2 wait states) and a zero-wait instance.
// Expectations for the misaligned case follow DMEM_ALIGN_CHECK_EN.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;

    logic        v0, w0, rdy0, rv0, er0;
    logic [31:0] a0, d0, rd0;
    logic        v1, w1, rdy1, rv1, er1;
    logic [31:0] a1, d1, rd1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .reset(rst_n),
        .req_valid(v0), .req_write(w0), .req_addr(a0), .req_wdata(d0),
        .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0)
    );

    dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .reset(rst_n),
        .req_valid(v1), .req_write(w1), .req_addr(a1), .req_wdata(d1),
        .req_ready(rdy1), .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response pulse is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rv0 === 1'b1) begin
                if (q0.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut0 unexpected response: got rdata %h, none expected", rd0);
                end else begin
                    e = q0.pop_front();
                    chk("dut0 rdata", rd0, e.rd);
                    chk("dut0 err", {31'd0, er0}, {31'd0, e.err});
                    chk("dut0 latency", cyc, e.cyc);
                end
            end
            if (rv1 === 1'b1) begin
                if (q1.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL dut1 unexpected response: got rdata %h, none expected", rd1);
                end else begin
                    e = q1.pop_front();
                    chk("dut1 rdata", rd1, e.rd);
                    chk("dut1 err", {31'd0, er1}, {31'd0, e.err});
                    chk("dut1 latency", cyc, e.cyc);
                end
            end
        end
    end

    task automatic issue(input int sel, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input bit exp_resp, input logic [31:0] exp_rd,
                         input logic exp_err, input bit hold, output int acc);
        int   n;
        logic rdy;
        exp_t e;
        acc = 0;
        if (sel == 0) begin
            v0 = 1'b1; w0 = wr; a0 = addr; d0 = wd;
        end else begin
            v1 = 1'b1; w1 = wr; a1 = addr; d1 = wd;
        end
        n   = 0;
        rdy = (sel == 0) ? rdy0 : rdy1;
        while (rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
            rdy = (sel == 0) ? rdy0 : rdy1;
        end
        if (rdy !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL accept timeout dut%0d addr %h: got ready %b, required 1", sel, addr, rdy);
            v0 = 1'b0;
            v1 = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) begin
            if (sel == 0) v0 = 1'b0;
            else          v1 = 1'b0;
        end
        if (exp_resp) begin
            e.rd  = exp_rd;
            e.err = exp_err;
            e.cyc = acc + ((sel == 0) ? 2 : 0);
            if (sel == 0) q0.push_back(e);
            else          q1.push_back(e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            vectors     += q0.size() + q1.size();
            miscompares += q0.size() + q1.size();
            $display("FAIL response timeout: got %0d/%0d pending, required 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int acc, acc1, acc2;
        logic        aln;
        logic [31:0] exp40;
`ifdef DMEM_ALIGN_CHECK_EN
        aln   = 1'b1;
        exp40 = 32'hCAFEF00D;
`else
        aln   = 1'b0;
        exp40 = 32'h00000055;
`endif
        rst_n = 1'b0;
        v0 = 1'b0; w0 = 1'b0; a0 = 32'd0; d0 = 32'd0;
        v1 = 1'b0; w1 = 1'b0; a1 = 32'd0; d1 = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset ready", {31'd0, rdy0}, 32'd1);
        chk("reset resp_valid", {31'd0, rv0}, 32'd0);
        chk("reset rdata", rd0, 32'd0);
        chk("reset err", {31'd0, er0}, 32'd0);
        chk("reset ready dut1", {31'd0, rdy1}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Write then read back with two wait states
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, acc);
        drain();
        repeat (2) @(negedge clk);
        chk("rdata holds after resp", rd0, 32'hDEADBEEF);

        // Zero wait states
        issue(1, 1'b1, 32'h20, 32'h12345678, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        issue(1, 1'b0, 32'h20, 32'h0, 1'b1, 32'h12345678, 1'b0, 1'b0, acc);
        drain();

        // Upper address bits alias onto word 0
        issue(0, 1'b1, 32'h400, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        issue(0, 1'b0, 32'h000, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, acc);
        drain();

        // Back-to-back reads with valid held high
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, acc1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ready low between accepts", {31'd0, rdy0}, 32'd0);
        end
        @(negedge clk);
        chk("ready back high", {31'd0, rdy0}, 32'd1);
        issue(0, 1'b0, 32'h000, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, acc2);
        chk("accept spacing", acc2 - acc1, 32'd4);
        drain();

        // Reset during WAIT aborts a write
        issue(0, 1'b1, 32'h30, 32'h11111111, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        drain();
        issue(0, 1'b1, 32'h30, 32'h22, 1'b0, 32'h0, 1'b0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("abort ready", {31'd0, rdy0}, 32'd1);
        chk("abort resp_valid", {31'd0, rv0}, 32'd0);
        chk("abort rdata", rd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(0, 1'b0, 32'h30, 32'h0, 1'b1, 32'h11111111, 1'b0, 1'b0, acc);
        drain();

        // Misaligned accesses
        issue(0, 1'b1, 32'h40, 32'hCAFEF00D, 1'b1, 32'h0, 1'b0, 1'b0, acc);
        issue(0, 1'b1, 32'h42, 32'h55, 1'b1, 32'h0, aln, 1'b0, acc);
        issue(0, 1'b0, 32'h40, 32'h0, 1'b1, exp40, 1'b0, 1'b0, acc);
        issue(0, 1'b0, 32'h41, 32'h0, 1'b1, aln ? 32'h0 : exp40, aln, 1'b0, acc);
        drain();
        repeat (2) @(negedge clk);
        chk("err low outside resp", {31'd0, er0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
